tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer: receives one serial stream of W-bit samples, one per slot, with a frame-sync marker on slot 0.
- Distributes each frame's samples to N_CH parallel channel outputs.
- Receive-side counterpart of the team's selection/mux blocks. Sits after the TDM link and before per-channel consumers.
- Double-buffered: consumers see a stable, complete frame while the next frame is being collected.

Parameters:
- N_CH, 4, number of channels/slots per frame; legal range 2..16.
- W, 8, sample width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  slot sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- dout  output  N_CH*W  completed frame; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse: dout has just been updated.
- locked  output  1  high while in LOCKED state.
- slot_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT, slot counter=0, shadow buffer=0.
  - dout=0, frame_valid=0, locked=0, slot_err=0.
- Slot counter:
  - Width is max(1,$clog2(N_CH)).
  - Advances only on an accepted sample. Wraps N_CH-1 -> 0.
- HUNT state:
  - Samples without frame_sync are discarded.
  - A sample with din_valid=1 and frame_sync=1 is written to shadow slot 0; counter=1; state goes to LOCKED.
- LOCKED state, for each din_valid=1 sample at counter c:
  - c!=0 and frame_sync=0: write shadow[c]; counter=c+1.
  - c==N_CH-1 (last slot): at the same edge, dout <= shadow with slot N_CH-1 replaced by din; frame_valid=1 for exactly the following cycle; counter=0.
  - c==0 and frame_sync=1: normal frame start; write shadow[0]; counter=1.
  - c==0 and frame_sync=0 (missing sync): slot_err pulse; sample dropped; state goes to HUNT; counter=0.
  - c!=0 and frame_sync=1 (early sync): slot_err pulse; partial frame is abandoned and dout is not updated; sample becomes new slot 0; counter=1; state stays LOCKED.
- Cycles with din_valid=0 change nothing except clearing the one-cycle pulses.
- Latency: frame_valid and new dout appear the cycle after the last-slot sample is presented.
- dout holds its value between frames. It is never partially updated.
- Shadow contents persist after an abandoned frame. Every slot is rewritten before the next dout update, so stale data never reaches dout.
- locked is a registered copy of (state==LOCKED).
- Back-to-back frames with din_valid=1 every cycle are sustained at full rate, with no bubble required.
- Reset asserted mid-frame: immediately returns everything to reset values; the partial frame is lost.
- frame_valid and slot_err are never high in the same cycle. The early-sync case does not update dout.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Adds input din_par (1 bit), the odd-parity bit over din.
  - Adds output frame_par_err (1 bit).
  - Each accepted sample's parity is checked (^{din,din_par} must be 1). Any failure within a frame sets an internal flag.
  - frame_par_err is asserted together with frame_valid, for that one cycle, if the flag is set; the flag then clears.
  - The flag also clears on frame abandonment and in HUNT.
  - Data is still delivered regardless of parity errors.
- Not defined: din_par and frame_par_err ports do not exist; no parity logic is present.

Test Plan:
- Reset then two full frames at N_CH=4, W=8, samples 0x11,0x22,0x33,0x44 then 0x55..0x88, with sync on the first sample of each -> dout=0x44332211 with frame_valid pulse one cycle after 0x44; then dout=0x88776655; slot_err never asserts.
- Stream of three samples without sync, then a synced frame -> first three samples ignored, locked=0 until the sync sample, then locked=1 and one frame_valid.
- Early sync on slot 2 -> slot_err pulse; no frame_valid; dout keeps its prior value; the next three samples complete a frame starting from the resync sample.
- Missing sync at slot 0 after a good frame -> slot_err pulse; locked=0 next cycle; the following samples are ignored until a sync arrives.
- din_valid toggling 1,0,1,0 across a frame -> identical dout to the gap-free case, with frame_valid only after the 4th valid sample.
- rst_n pulsed low mid-frame (after 2 samples) -> all outputs 0 immediately; the next synced frame is delivered correctly. With TDM_DEMUX_PARITY_EN, a bad-parity sample in slot 1 -> frame_par_err=1 coincident with frame_valid, and 0 for the next clean frame.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: collects one frame of N_CH slot samples into a shadow buffer
// and publishes it to dout atomically. Optional odd-parity checking under TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic              din_par,
  output logic              frame_par_err,
`endif
  output logic [N_CH*W-1:0] dout,
  output logic              frame_valid,
  output logic              locked,
  output logic              slot_err
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_CH*W-1:0]   shadow_q, shadow_d;
  logic [N_CH*W-1:0]   dout_q, dout_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                locked_q;
`ifdef TDM_DEMUX_PARITY_EN
  logic                par_flag_q, par_flag_d;
  logic                par_err_q, par_err_d;
  logic                par_bad;

  assign par_bad = ~(^{din, din_par});
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_flag_d = (state_q == HUNT) ? 1'b0 : par_flag_q;
    par_err_d  = 1'b0;
`endif
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          shadow_d[W-1:0] = din;
          cnt_d           = CW'(1);
          state_d         = LOCKED;
`ifdef TDM_DEMUX_PARITY_EN
          par_flag_d      = par_bad;
`endif
        end
      end else if (cnt_q == '0) begin
        if (frame_sync) begin
          shadow_d[W-1:0] = din;
          cnt_d           = CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
          par_flag_d      = par_bad;
`endif
        end else begin
          // Lost alignment: drop the sample and re-hunt for sync.
          err_d   = 1'b1;
          state_d = HUNT;
          cnt_d   = '0;
`ifdef TDM_DEMUX_PARITY_EN
          par_flag_d = 1'b0;
`endif
        end
      end else if (frame_sync) begin
        // Early sync restarts the frame; old shadow slots get overwritten before next publish.
        err_d           = 1'b1;
        shadow_d[W-1:0] = din;
        cnt_d           = CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
        par_flag_d      = par_bad;
`endif
      end else if (cnt_q == LAST) begin
        shadow_d[(N_CH-1)*W +: W] = din;
        dout_d                    = shadow_q;
        dout_d[(N_CH-1)*W +: W]   = din;
        fv_d                      = 1'b1;
        cnt_d                     = '0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d  = par_flag_q | par_bad;
        par_flag_d = 1'b0;
`endif
      end else begin
        shadow_d[int'(cnt_q)*W +: W] = din;
        cnt_d                        = cnt_q + CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
        par_flag_d = par_flag_q | par_bad;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_flag_q <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
`ifdef TDM_DEMUX_PARITY_EN
      par_flag_q <= par_flag_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign slot_err    = err_q;
  assign locked      = locked_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign frame_par_err = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8); parity steps run only with TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic        din_par = 1'b1;
  logic        bad_par = 1'b0;
  logic [31:0] dout;
  logic        frame_valid, locked, slot_err;
  logic        frame_par_err;
  int          tests = 0;
  int          fails = 0;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par     (din_par),
    .frame_par_err(frame_par_err),
`endif
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot_err    (slot_err)
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign frame_par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one input cycle; returns 1ns after the capturing edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din        = d;
    din_valid  = v;
    frame_sync = s;
    din_par    = bad_par ? (^d) : ~(^d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_fv", {31'b0, frame_valid}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);
    chk("rst_err", {31'b0, slot_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back frames
    step(1, 1, 8'h11);
    chk("f1_locked", {31'b0, locked}, 32'h1);
    chk("f1_fv_early", {31'b0, frame_valid}, 32'h0);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    chk("f1_fv_s2", {31'b0, frame_valid}, 32'h0);
    step(1, 0, 8'h44);
    chk("f1_fv", {31'b0, frame_valid}, 32'h1);
    chk("f1_dout", dout, 32'h44332211);
    chk("f1_err", {31'b0, slot_err}, 32'h0);
    step(1, 1, 8'h55);
    chk("f2_fv_clr", {31'b0, frame_valid}, 32'h0);
    chk("f2_dout_hold", dout, 32'h44332211);
    step(1, 0, 8'h66);
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    chk("f2_fv", {31'b0, frame_valid}, 32'h1);
    chk("f2_dout", dout, 32'h88776655);
    chk("f2_err", {31'b0, slot_err}, 32'h0);

    // Missing sync at slot 0, then unsynced samples ignored
    step(1, 0, 8'hAA);
    chk("miss_err", {31'b0, slot_err}, 32'h1);
    chk("miss_locked", {31'b0, locked}, 32'h0);
    chk("miss_fv", {31'b0, frame_valid}, 32'h0);
    chk("miss_dout", dout, 32'h88776655);
    step(1, 0, 8'hBB);
    chk("hunt_err_clr", {31'b0, slot_err}, 32'h0);
    chk("hunt_locked1", {31'b0, locked}, 32'h0);
    step(1, 0, 8'hCC);
    chk("hunt_locked2", {31'b0, locked}, 32'h0);
    step(1, 1, 8'h01);
    chk("hunt_lock", {31'b0, locked}, 32'h1);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    step(1, 0, 8'h04);
    chk("hunt_fv", {31'b0, frame_valid}, 32'h1);
    chk("hunt_dout", dout, 32'h04030201);

    // Early sync on slot 2
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h30);
    chk("early_err", {31'b0, slot_err}, 32'h1);
    chk("early_fv", {31'b0, frame_valid}, 32'h0);
    chk("early_dout", dout, 32'h04030201);
    chk("early_locked", {31'b0, locked}, 32'h1);
    step(1, 0, 8'h40);
    chk("early_err_clr", {31'b0, slot_err}, 32'h0);
    step(1, 0, 8'h50);
    chk("early_fv_s2", {31'b0, frame_valid}, 32'h0);
    step(1, 0, 8'h60);
    chk("resync_fv", {31'b0, frame_valid}, 32'h1);
    chk("resync_dout", dout, 32'h60504030);

    // din_valid toggling across a frame
    step(1, 1, 8'hA1);
    step(0, 1, 8'hFF);
    step(1, 0, 8'hA2);
    step(0, 0, 8'hEE);
    step(1, 0, 8'hA3);
    step(0, 0, 8'hDD);
    chk("gap_fv_early", {31'b0, frame_valid}, 32'h0);
    chk("gap_err", {31'b0, slot_err}, 32'h0);
    step(1, 0, 8'hA4);
    chk("gap_fv", {31'b0, frame_valid}, 32'h1);
    chk("gap_dout", dout, 32'hA4A3A2A1);
    step(0, 0, 8'h00);
    chk("gap_fv_clr", {31'b0, frame_valid}, 32'h0);
    chk("gap_dout_hold", dout, 32'hA4A3A2A1);

    // Reset mid-frame
    step(1, 1, 8'hB1);
    step(1, 0, 8'hB2);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_dout", dout, 32'h0);
    chk("mrst_locked", {31'b0, locked}, 32'h0);
    chk("mrst_fv", {31'b0, frame_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'hB3);
    chk("mrst_hunt", {31'b0, locked}, 32'h0);
    step(1, 1, 8'hC1);
    step(1, 0, 8'hC2);
    step(1, 0, 8'hC3);
    step(1, 0, 8'hC4);
    chk("mrst_fv_after", {31'b0, frame_valid}, 32'h1);
    chk("mrst_dout_after", dout, 32'hC4C3C2C1);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity in slot 1, then a clean frame
    step(1, 1, 8'hD1);
    bad_par = 1'b1;
    step(1, 0, 8'hD2);
    bad_par = 1'b0;
    step(1, 0, 8'hD3);
    step(1, 0, 8'hD4);
    chk("par_fv", {31'b0, frame_valid}, 32'h1);
    chk("par_err", {31'b0, frame_par_err}, 32'h1);
    chk("par_dout", dout, 32'hD4D3D2D1);
    step(1, 1, 8'hE1);
    chk("par_err_clr", {31'b0, frame_par_err}, 32'h0);
    step(1, 0, 8'hE2);
    step(1, 0, 8'hE3);
    step(1, 0, 8'hE4);
    chk("par_clean_fv", {31'b0, frame_valid}, 32'h1);
    chk("par_clean_err", {31'b0, frame_par_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
